// File: rtl/vx_fetch_credit_sched_pkg.sv
// Shared types and helpers for the warp fetch credit scheduler.
//   FS_*                default sizing (4 warps, 4 ibuffer entries per warp)
//   fetch_sched_req_t   fetch request payload shared with downstream fetch logic
//   crd_op_e            per-warp credit operation in one cycle (take/return)
//   credit_next()       saturating credit update rule
package vx_fetch_credit_sched_pkg;

  localparam int FS_NUM_WARPS = 4;
  localparam int FS_IBUF_SIZE = 4;
  localparam int FS_NW_WIDTH  = $clog2(FS_NUM_WARPS);
  localparam int FS_CRD_WIDTH = $clog2(FS_IBUF_SIZE + 1);

  typedef struct packed {
    logic [FS_NW_WIDTH-1:0] wid;
  } fetch_sched_req_t;

  typedef enum logic [1:0] {
    CRD_HOLD = 2'b00,
    CRD_RET  = 2'b01,
    CRD_TAKE = 2'b10,
    CRD_BOTH = 2'b11
  } crd_op_e;

  // A return on a counter that is already full is dropped rather than wrapped,
  // so stale pops (e.g. for entries issued before a reset) cannot corrupt it.
  function automatic int credit_next(input int cur, input logic take,
                                     input logic ret, input int max_credits);
    int nxt;
    nxt = cur;
    case (crd_op_e'({take, ret}))
      CRD_TAKE: nxt = cur - 1;
      CRD_RET:  nxt = (cur >= max_credits) ? cur : cur + 1;
      CRD_BOTH: nxt = cur;
      CRD_HOLD: nxt = cur;
      default:  nxt = cur;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/vx_fetch_credit_sched_chk.sv
// Simulation-only checker for the credit counters.
//   credits  flattened per-warp credit counts
//   grant    per-warp grant this cycle
//   pop      per-warp ibuffer pop this cycle
module vx_fetch_credit_sched_chk #(
  parameter int NUM_WARPS = 4,
  parameter int IBUF_SIZE = 4,
  parameter int CRD_WIDTH = 3
) (
  input logic                           clk,
  input logic                           reset,
  input logic [NUM_WARPS*CRD_WIDTH-1:0] credits,
  input logic [NUM_WARPS-1:0]           grant,
  input logic [NUM_WARPS-1:0]           pop
);

  // Flag dropped pops on full counters and grants against empty counters.
  always @(posedge clk) begin
    if (!reset) begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        assert (!(pop[w] && !grant[w] &&
                  (credits[w*CRD_WIDTH +: CRD_WIDTH] == CRD_WIDTH'(IBUF_SIZE))))
          else $warning("warp %0d: ibuf_pop on full credit counter dropped", w);
        assert (!(grant[w] && (credits[w*CRD_WIDTH +: CRD_WIDTH] == {CRD_WIDTH{1'b0}})))
          else $error("warp %0d: grant issued with zero credits", w);
      end
    end
  end

endmodule

// File: rtl/vx_fetch_rr_pick.sv
// Combinational round-robin picker.
//   req           request vector
//   last          index granted most recently; scanning starts at last+1
//   grant_onehot  one-hot winner (all zero when nothing requests)
//   grant_idx     binary index of the winner
//   any_valid     at least one request present
module vx_fetch_rr_pick #(
  parameter  int NUM_REQ   = 4,
  localparam int IDX_WIDTH = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]   req,
  input  logic [IDX_WIDTH-1:0] last,
  output logic [NUM_REQ-1:0]   grant_onehot,
  output logic [IDX_WIDTH-1:0] grant_idx,
  output logic                 any_valid
);

  // Index that lies 'step' positions after 'base', wrapping at NUM_REQ.
  function automatic logic [IDX_WIDTH-1:0] wrap_idx(input logic [IDX_WIDTH-1:0] base,
                                                    input int step);
    return IDX_WIDTH'((int'(base) + step) % NUM_REQ);
  endfunction

  // Scan last+1 .. last+NUM_REQ (last itself checked last) and take the first hit.
  always_comb begin
    grant_onehot = {NUM_REQ{1'b0}};
    grant_idx    = {IDX_WIDTH{1'b0}};
    any_valid    = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!any_valid && req[wrap_idx(last, k)]) begin
        any_valid                       = 1'b1;
        grant_idx                       = wrap_idx(last, k);
        grant_onehot[wrap_idx(last, k)] = 1'b1;
      end else begin
        any_valid = any_valid;
      end
    end
  end

endmodule

// File: rtl/vx_fetch_credit_sched.sv
// Warp fetch scheduler with per-warp ibuffer credits.
//   clk, reset    clock, asynchronous active-high reset
//   warp_active   warp is running
//   warp_stall    warp temporarily blocked
//   ibuf_pop      one ibuffer entry of warp w freed (1-cycle pulse)
//   req_valid     fetch request valid (held until req_ready)
//   req_wid       warp id of the fetch request
//   req_ready     fetch stage accepts the request
//   credits_out   flattened credit counts, warp w at [w*CRD_WIDTH +: CRD_WIDTH]
//   idle          no request pending and every credit returned
module vx_fetch_credit_sched
  import vx_fetch_credit_sched_pkg::*;
#(
  parameter  int NUM_WARPS = FS_NUM_WARPS,
  parameter  int IBUF_SIZE = FS_IBUF_SIZE,
  localparam int NW_WIDTH  = $clog2(NUM_WARPS),
  localparam int CRD_WIDTH = $clog2(IBUF_SIZE + 1)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_WARPS-1:0]           warp_active,
  input  logic [NUM_WARPS-1:0]           warp_stall,
  input  logic [NUM_WARPS-1:0]           ibuf_pop,
  output logic                           req_valid,
  output logic [NW_WIDTH-1:0]            req_wid,
  input  logic                           req_ready,
  output logic [NUM_WARPS*CRD_WIDTH-1:0] credits_out,
  output logic                           idle
);

  logic [CRD_WIDTH-1:0] credits_r     [NUM_WARPS];
  logic [CRD_WIDTH-1:0] credits_nxt_s [NUM_WARPS];
  logic [NUM_WARPS-1:0] eligible_s;
  logic [NUM_WARPS-1:0] pick_onehot_s;
  logic [NUM_WARPS-1:0] grant_vec_s;
  logic [NW_WIDTH-1:0]  pick_idx_s;
  logic [NW_WIDTH-1:0]  last_r;
  logic [NW_WIDTH-1:0]  req_wid_r;
  logic                 pick_any_s;
  logic                 slot_open_s;
  logic                 grant_fire_s;
  logic                 req_valid_r;
  logic                 all_full_s;

  // Eligibility looks only at registered credits, so a pop helps one cycle later.
  always_comb begin
    eligible_s = {NUM_WARPS{1'b0}};
    for (int w = 0; w < NUM_WARPS; w++) begin
      eligible_s[w] = warp_active[w] & ~warp_stall[w] &
                      (credits_r[w] != {CRD_WIDTH{1'b0}});
    end
  end

  vx_fetch_rr_pick #(
    .NUM_REQ (NUM_WARPS)
  ) u_rr_pick (
    .req          (eligible_s),
    .last         (last_r),
    .grant_onehot (pick_onehot_s),
    .grant_idx    (pick_idx_s),
    .any_valid    (pick_any_s)
  );

  // A new grant may only be issued when no request is stuck waiting for ready.
  assign slot_open_s  = ~req_valid_r | req_ready;
  assign grant_fire_s = slot_open_s & pick_any_s;
  assign grant_vec_s  = grant_fire_s ? pick_onehot_s : {NUM_WARPS{1'b0}};

  // Next credit value per warp: minus grant, plus pop, pops on full dropped.
  always_comb begin
    for (int w = 0; w < NUM_WARPS; w++) begin
      credits_nxt_s[w] = CRD_WIDTH'(credit_next(int'(credits_r[w]), grant_vec_s[w],
                                                ibuf_pop[w], IBUF_SIZE));
    end
  end

  // Credit counters: all slots free after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        credits_r[w] <= CRD_WIDTH'(IBUF_SIZE);
      end
    end else begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        credits_r[w] <= credits_nxt_s[w];
      end
    end
  end

  // Request register and round-robin pointer; both hold while a request waits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_valid_r <= 1'b0;
      req_wid_r   <= {NW_WIDTH{1'b0}};
      last_r      <= NW_WIDTH'(NUM_WARPS - 1);
    end else if (slot_open_s) begin
      req_valid_r <= pick_any_s;
      if (pick_any_s) begin
        req_wid_r <= pick_idx_s;
        last_r    <= pick_idx_s;
      end else begin
        req_wid_r <= req_wid_r;
        last_r    <= last_r;
      end
    end else begin
      req_valid_r <= req_valid_r;
      req_wid_r   <= req_wid_r;
      last_r      <= last_r;
    end
  end

  // Every counter back at IBUF_SIZE means no instruction is in flight.
  always_comb begin
    all_full_s = 1'b1;
    for (int w = 0; w < NUM_WARPS; w++) begin
      if (credits_r[w] != CRD_WIDTH'(IBUF_SIZE)) begin
        all_full_s = 1'b0;
      end else begin
        all_full_s = all_full_s;
      end
    end
  end

  // Flatten the counters for the debug/perf port.
  always_comb begin
    credits_out = {(NUM_WARPS*CRD_WIDTH){1'b0}};
    for (int w = 0; w < NUM_WARPS; w++) begin
      credits_out[w*CRD_WIDTH +: CRD_WIDTH] = credits_r[w];
    end
  end

  assign req_valid = req_valid_r;
  assign req_wid   = req_wid_r;
  assign idle      = ~req_valid_r & all_full_s;

  vx_fetch_credit_sched_chk #(
    .NUM_WARPS (NUM_WARPS),
    .IBUF_SIZE (IBUF_SIZE),
    .CRD_WIDTH (CRD_WIDTH)
  ) u_chk (
    .clk     (clk),
    .reset   (reset),
    .credits (credits_out),
    .grant   (grant_vec_s),
    .pop     (ibuf_pop)
  );

endmodule

// File: tb/tb_vx_fetch_credit_sched.sv
module tb_vx_fetch_credit_sched;

  localparam int NW = 4;
  localparam int IB = 4;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [NW-1:0] warp_active = '0;
  logic [NW-1:0] warp_stall = '0;
  logic [NW-1:0] ibuf_pop = '0;
  logic          req_ready = 1'b0;
  logic          req_valid;
  logic [1:0]    req_wid;
  logic [NW*CW-1:0] credits_out;
  logic          idle;

  vx_fetch_credit_sched #(.NUM_WARPS(NW), .IBUF_SIZE(IB)) dut (
    .clk(clk), .reset(reset), .warp_active(warp_active), .warp_stall(warp_stall),
    .ibuf_pop(ibuf_pop), .req_valid(req_valid), .req_wid(req_wid),
    .req_ready(req_ready), .credits_out(credits_out), .idle(idle)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: credits per warp, last granted warp, pending request.
  int m_cred[NW];
  int m_last;
  bit m_valid;
  int m_wid;

  typedef struct {
    logic [NW-1:0] active;
    logic [NW-1:0] stall;
    logic          ready;
    logic          exp_valid;
    int            exp_wid;
    logic          exp_idle;
  } vec_t;
  vec_t tbl[17];

  function automatic int cred(input int w);
    return int'(credits_out[w*CW +: CW]);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int w = 0; w < NW; w++) m_cred[w] = IB;
    m_last  = NW - 1;
    m_valid = 1'b0;
    m_wid   = 0;
  endtask

  // One clock edge of the scheduling rules, from the inputs presented now.
  task automatic model_step();
    bit open;
    int pick;
    open = !m_valid || req_ready;
    pick = -1;
    if (open) begin
      for (int k = 1; k <= NW; k++) begin
        int w;
        w = (m_last + k) % NW;
        if (pick < 0 && warp_active[w] && !warp_stall[w] && m_cred[w] > 0) pick = w;
      end
    end
    for (int w = 0; w < NW; w++) begin
      m_cred[w] = m_cred[w] - ((w == pick) ? 1 : 0) + (ibuf_pop[w] ? 1 : 0);
      if (m_cred[w] > IB) m_cred[w] = IB;
    end
    if (open) begin
      m_valid = (pick >= 0);
      if (pick >= 0) begin
        m_wid  = pick;
        m_last = pick;
      end
    end
  endtask

  task automatic compare_model();
    bit all_full;
    all_full = 1'b1;
    check("model_valid", int'(req_valid), int'(m_valid));
    if (m_valid) check("model_wid", int'(req_wid), m_wid);
    for (int w = 0; w < NW; w++) begin
      check($sformatf("model_cred%0d", w), cred(w), m_cred[w]);
      if (m_cred[w] != IB) all_full = 1'b0;
    end
    check("model_idle", int'(idle), int'(!m_valid && all_full));
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    ibuf_pop = '0;
    compare_model();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    warp_active = '0;
    warp_stall = '0;
    ibuf_pop = '0;
    req_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 17; i++) begin
      tbl[i] = '{active: 4'hF, stall: 4'h0, ready: 1'b1,
                 exp_valid: (i < 16), exp_wid: i % 4, exp_idle: 1'b0};
    end

    // Reset state
    do_reset();
    check("rst_valid", int'(req_valid), 0);
    check("rst_wid", int'(req_wid), 0);
    check("rst_idle", int'(idle), 1);
    for (int w = 0; w < NW; w++) check("rst_cred", cred(w), IB);

    // Test 1: round-robin over all warps until credits run out
    foreach (tbl[i]) begin
      warp_active = tbl[i].active;
      warp_stall  = tbl[i].stall;
      req_ready   = tbl[i].ready;
      tick();
      check($sformatf("t1_valid[%0d]", i), int'(req_valid), int'(tbl[i].exp_valid));
      if (tbl[i].exp_valid) check($sformatf("t1_wid[%0d]", i), int'(req_wid), tbl[i].exp_wid);
      check($sformatf("t1_idle[%0d]", i), int'(idle), int'(tbl[i].exp_idle));
    end
    for (int w = 0; w < NW; w++) check("t1_cred_empty", cred(w), 0);

    // Test 2: held request survives stall toggling while not ready
    do_reset();
    warp_active = 4'b0100;
    req_ready = 1'b0;
    tick();
    check("t2_first_valid", int'(req_valid), 1);
    check("t2_first_wid", int'(req_wid), 2);
    for (int c = 0; c < 5; c++) begin
      warp_stall = (c % 2 == 0) ? 4'b0100 : 4'b0000;
      tick();
      check("t2_hold_valid", int'(req_valid), 1);
      check("t2_hold_wid", int'(req_wid), 2);
      check("t2_hold_cred", cred(2), 3);
    end
    warp_stall = '0;
    req_ready = 1'b1;
    tick();
    check("t2_next_wid", int'(req_wid), 2);
    check("t2_next_cred", cred(2), 2);

    // Test 3: pop on an empty warp re-enables it two cycles later
    do_reset();
    warp_active = 4'b0010;
    req_ready = 1'b1;
    repeat (5) tick();
    check("t3_empty_cred", cred(1), 0);
    check("t3_empty_valid", int'(req_valid), 0);
    ibuf_pop = 4'b0010;
    tick();
    check("t3_pop_cred", cred(1), 1);
    check("t3_pop_valid", int'(req_valid), 0);
    tick();
    check("t3_regrant_valid", int'(req_valid), 1);
    check("t3_regrant_wid", int'(req_wid), 1);

    // Test 4: grant and pop on the same warp in one cycle
    do_reset();
    warp_active = 4'b0001;
    req_ready = 1'b1;
    repeat (2) tick();
    check("t4_pre_cred", cred(0), 2);
    ibuf_pop = 4'b0001;
    tick();
    check("t4_same_cred", cred(0), 2);
    check("t4_same_valid", int'(req_valid), 1);

    // Test 5: pop to a full warp is dropped
    do_reset();
    ibuf_pop = 4'b1000;
    tick();
    check("t5_cred3", cred(3), IB);
    check("t5_idle", int'(idle), 1);

    // Test 6: asynchronous reset in the middle of traffic
    do_reset();
    req_ready = 1'b1;
    warp_active = 4'b1111; repeat (4) tick();
    warp_active = 4'b1101; repeat (3) tick();
    warp_active = 4'b1100; repeat (2) tick();
    warp_active = 4'b0100; tick();
    check("t6_pre_valid", int'(req_valid), 1);
    check("t6_pre_cred0", cred(0), 2);
    check("t6_pre_cred1", cred(1), 3);
    check("t6_pre_cred2", cred(2), 0);
    check("t6_pre_cred3", cred(3), 1);
    #1;
    reset = 1'b1;
    model_reset();
    #1;
    check("t6_rst_valid", int'(req_valid), 0);
    for (int w = 0; w < NW; w++) check("t6_rst_cred", cred(w), IB);
    #1;
    reset = 1'b0;
    warp_active = 4'b1111;
    tick();
    check("t6_post_wid", int'(req_wid), 0);

    // Randomised traffic against the model
    do_reset();
    for (int c = 0; c < 400; c++) begin
      warp_active = 4'($urandom_range(0, 15));
      warp_stall  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
      req_ready   = ($urandom_range(0, 3) != 0);
      for (int w = 0; w < NW; w++) begin
        ibuf_pop[w] = ($urandom_range(0, 2) == 0) && (m_cred[w] < IB);
      end
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
